radix_fft_agu: RTL and testbench

RADIX_FFT_AGU -- requirements
Module: radix_fft_agu

---
 rtl/radix_fft_agu.sv | 158 +++++++++++++++
 tb/tb_radix_fft_agu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix_fft_agu.sv
// radix_fft_agu: radix-2^LOG_R FFT address generator (bank, bank address, twiddle ROM address per group).
// Latency: every output is registered one cycle after its issuing cycle; stage_dly trails stage by ST_DLY.
// Backpressure: en=0 stalls the sequence, valid drops and the other outputs hold their last values.
// Optional feature: define AGU_STAGE_DLY_EN to build the ST_DLY-deep stage tag pipeline.
module radix_fft_agu #(
  parameter int LOG_R  = 4,
  parameter int NUM_ST = 4,
  parameter int ST_DLY = 48,
  localparam int W  = LOG_R * (NUM_ST - 1),
  localparam int SW = (NUM_ST > 1) ? $clog2(NUM_ST) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rc_mode,
  input  logic          en,
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic          bn,
  output logic [W-2:0]  ma,
  output logic [W-1:0]  roma,
  output logic [W-1:0]  dig,
  output logic [SW-1:0] stage,
  output logic [SW-1:0] stage_dly
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SW-1:0] ST_LAST = SW'(NUM_ST - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  cnt, cnt_nxt;
  logic [SW-1:0] st, st_nxt;
  logic          mode, mode_nxt;
  logic          issue;
  logic          last;
  int unsigned   rot_sh;
  logic [W-1:0]  rot;
  logic [W-1:0]  rev;
  logic [W-1:0]  bc;
  logic [W-1:0]  roma_nxt;

  // Butterfly address: rotate by the stage's digit offset, or digit-reverse for a reorder pass.
  always_comb begin
    rot_sh = (LOG_R * int'(st)) % W;
    rot    = '0;
    for (int b = 0; b < W; b++) begin
      rot[b] = cnt[(b + rot_sh) % W];
    end
    rev = '0;
    for (int k = 0; k < NUM_ST - 1; k++) begin
      rev[LOG_R*k +: LOG_R] = cnt[LOG_R*(NUM_ST-2-k) +: LOG_R];
    end
    bc       = mode ? rev : rot;
    roma_nxt = '0;
    if (!mode && (st != ST_LAST)) begin
      roma_nxt = bc << (LOG_R * int'(st));
    end
  end

  // Sequencer next state: a group issues on every enabled RUN cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st_nxt    = st;
    mode_nxt  = mode;
    issue     = 1'b0;
    last      = (cnt == '1) && (mode ? (st == '0) : (st == ST_LAST));
    case (state)
      IDLE: begin
        // done still high means this is the pass's final output cycle; a start here is dropped.
        if (start && !done) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          st_nxt    = '0;
          mode_nxt  = rc_mode;
        end
      end
      RUN: begin
        if (en) begin
          issue   = 1'b1;
          cnt_nxt = cnt + W'(1);
          if (cnt == '1) begin
            st_nxt = st + SW'(1);
          end
          if (last) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, group counter, stage counter and latched mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      st    <= st_nxt;
      mode  <= mode_nxt;
    end
  end

  // Registered address outputs; only refreshed when a group issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      done  <= 1'b0;
      bn    <= 1'b0;
      ma    <= '0;
      roma  <= '0;
      dig   <= '0;
      stage <= '0;
    end else begin
      valid <= issue;
      done  <= issue && last;
      if (issue) begin
        bn    <= ^bc;
        ma    <= bc[W-1:1];
        roma  <= roma_nxt;
        dig   <= cnt;
        stage <= st;
      end
    end
  end

  assign busy = (state == RUN);

`ifdef AGU_STAGE_DLY_EN
  logic [SW-1:0] dly_pipe [ST_DLY];

  // Stage tag delay line: free-running, re-captures stage only on valid groups.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ST_DLY; i++) begin
        dly_pipe[i] <= '0;
      end
    end else begin
      dly_pipe[0] <= valid ? stage : dly_pipe[0];
      for (int i = 1; i < ST_DLY; i++) begin
        dly_pipe[i] <= dly_pipe[i-1];
      end
    end
  end

  assign stage_dly = dly_pipe[ST_DLY-1];
`else
  assign stage_dly = stage;
`endif

endmodule

// File: tb/tb_radix_fft_agu.sv
// tb_radix_fft_agu: scoreboard bench for radix_fft_agu at default parameters.
// Stimulus pushes the expected group per enabled cycle; a negedge monitor pops on valid.
// Covers reset, full and reorder passes, stalls, ignored starts and mid-pass reset.
module tb_radix_fft_agu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rc_mode;
  logic        en;
  logic        busy;
  logic        done;
  logic        valid;
  logic        bn;
  logic [10:0] ma;
  logic [11:0] roma;
  logic [11:0] dig;
  logic [1:0]  stage;
  logic [1:0]  stage_dly;

  radix_fft_agu dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rc_mode   (rc_mode),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .bn        (bn),
    .ma        (ma),
    .roma      (roma),
    .dig       (dig),
    .stage     (stage),
    .stage_dly (stage_dly)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] dig;
    logic [1:0]  stage;
    logic        done;
    logic        chk;
    logic        bn;
    logic [10:0] ma;
    logic [11:0] roma;
  } exp_t;

  exp_t q[$];

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_valid = 0;
  int n_vec   = 0;
  int cyc     = 0;
  int t_st1   = -1;
  int t_dly1  = -1;

  logic [11:0] m_cnt;
  logic [1:0]  m_st;
  logic        m_mode;
  logic [11:0] last_dig;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference sequence: expected group for one enabled cycle, then advance the model.
  task automatic push_expected();
    exp_t        e;
    logic [14:0] key;
    e.dig   = m_cnt;
    e.stage = m_st;
    e.done  = (m_cnt == 12'hFFF) && (m_mode ? (m_st == 2'd0) : (m_st == 2'd3));
    e.chk   = 1'b1;
    key     = {m_mode, m_st, m_cnt};
    case (key)
      {1'b0, 2'd1, 12'h123}: {e.bn, e.ma, e.roma} = {1'b0, 11'h189, 12'h120};
      {1'b0, 2'd3, 12'hABC}: {e.bn, e.ma, e.roma} = {1'b1, 11'h55E, 12'h000};
      {1'b0, 2'd2, 12'h800}: {e.bn, e.ma, e.roma} = {1'b1, 11'h004, 12'h800};
      {1'b0, 2'd0, 12'h123}: {e.bn, e.ma, e.roma} = {1'b0, 11'h091, 12'h123};
      {1'b0, 2'd0, 12'hFFF}: {e.bn, e.ma, e.roma} = {1'b0, 11'h7FF, 12'hFFF};
      {1'b0, 2'd2, 12'h123}: {e.bn, e.ma, e.roma} = {1'b0, 11'h118, 12'h100};
      {1'b0, 2'd1, 12'hFFF}: {e.bn, e.ma, e.roma} = {1'b0, 11'h7FF, 12'hFF0};
      {1'b1, 2'd0, 12'h124}: {e.bn, e.ma, e.roma} = {1'b1, 11'h210, 12'h000};
      {1'b1, 2'd0, 12'hFFF}: {e.bn, e.ma, e.roma} = {1'b0, 11'h7FF, 12'h000};
      {1'b1, 2'd0, 12'h001}: {e.bn, e.ma, e.roma} = {1'b1, 11'h080, 12'h000};
      {1'b1, 2'd0, 12'h123}: {e.bn, e.ma, e.roma} = {1'b0, 11'h190, 12'h000};
      default: begin
        e.chk  = 1'b0;
        e.bn   = 1'b0;
        e.ma   = '0;
        e.roma = '0;
      end
    endcase
    if (e.chk) n_vec++;
    q.push_back(e);
    last_dig = m_cnt;
    if (m_cnt == 12'hFFF) m_st = m_st + 2'd1;
    m_cnt = m_cnt + 12'd1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_done"},  done,      0);
    chk({tag, "_valid"}, valid,     0);
    chk({tag, "_bn"},    bn,        0);
    chk({tag, "_ma"},    ma,        0);
    chk({tag, "_roma"},  roma,      0);
    chk({tag, "_dig"},   dig,       0);
    chk({tag, "_stage"}, stage,     0);
    chk({tag, "_sdly"},  stage_dly, 0);
  endtask

  // One complete pass; optional start pulse mid-run and an en=1,0,0,1 stall.
  task automatic run_pass(input logic md, input int n, input int start_at, input int gap_at);
    logic stall_chk;
    stall_chk = 1'b0;
    n_valid   = 0;
    @(negedge clk);
    start   = 1'b1;
    rc_mode = md;
    en      = 1'b0;
    m_cnt   = '0;
    m_st    = '0;
    m_mode  = md;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("busy_after_start", busy, 1);
        chk("no_valid_before_issue", valid, 0);
      end
      if (stall_chk) begin
        chk("stall2_valid", valid, 0);
        chk("stall2_hold", dig, last_dig);
        stall_chk = 1'b0;
      end
      start = (i == start_at);
      if (i == start_at) rc_mode = ~md;
      en = 1'b1;
      push_expected();
      if (i == gap_at) begin
        @(negedge clk);
        start = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        chk("stall1_valid", valid, 0);
        chk("stall1_hold", dig, last_dig);
        stall_chk = 1'b1;
      end
    end
    // Final output cycle: try to restart right on top of done.
    @(negedge clk);
    chk("done_cycle_done", done, 1);
    chk("done_cycle_busy", busy, 0);
    start   = 1'b1;
    rc_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_ignored", busy, 0);
    chk("idle_valid", valid, 0);
    repeat (2) @(negedge clk);
    chk("stay_idle", busy, 0);
    chk("valid_count", n_valid, n);
    chk("queue_drained", q.size(), 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    logic ok;
    logic sdly_ok;
    cyc++;
    if (rst === 1'b1) begin
      t_st1  = -1;
      t_dly1 = -1;
    end else begin
      if (t_st1 < 0 && stage == 2'd1) t_st1 = cyc;
      if (t_dly1 < 0 && stage_dly == 2'd1) t_dly1 = cyc;
    end
    if (valid === 1'b1) begin
      n_valid++;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: got dig=%h st=%0d with no group expected", dig, stage);
      end else begin
        e = q.pop_front();
`ifdef AGU_STAGE_DLY_EN
        sdly_ok = 1'b1;
`else
        sdly_ok = (stage_dly == stage);
`endif
        ok = (dig == e.dig) && (stage == e.stage) && (done == e.done) &&
             (busy == !e.done) && sdly_ok;
        if (e.chk) ok = ok && (bn == e.bn) && (ma == e.ma) && (roma == e.roma);
        if (!ok) begin
          n_bad++;
          $display("FAIL group: got dig=%h st=%0d done=%b busy=%b bn=%b ma=%h roma=%h sdly=%0d want dig=%h st=%0d done=%b busy=%b bn=%b ma=%h roma=%h (addr checked=%b)",
                   dig, stage, done, busy, bn, ma, roma, stage_dly,
                   e.dig, e.stage, e.done, !e.done, e.bn, e.ma, e.roma, e.chk);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of run, want $finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    rc_mode = 1'b0;
    en      = 1'b0;
    m_cnt   = '0;
    m_st    = '0;
    m_mode  = 1'b0;
    last_dig = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", busy, 0);

    // Full FFT pass with a start pulse while running (ignored).
    run_pass(1'b0, 16384, 100, -1);
    // Reorder pass with an en stall.
    run_pass(1'b1, 4096, -1, 50);

    // Abort a full pass right after group cnt=0x800 of stage 2 issues.
    @(negedge clk);
    start   = 1'b1;
    rc_mode = 1'b0;
    m_cnt   = '0;
    m_st    = '0;
    m_mode  = 1'b0;
    for (int i = 0; i <= 10240; i++) begin
      @(negedge clk);
      start = 1'b0;
      en    = 1'b1;
      push_expected();
    end
    chk("abort_point", {m_st, last_dig}, {2'd2, 12'h800});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("abort");
    chk("abort_queue", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("abort_stay_idle", busy, 0);
    chk("abort_no_valid", valid, 0);

    // Fresh start after the abort must begin at cnt=0, st=0.
    run_pass(1'b0, 16384, -1, -1);

    chk("directed_vectors_hit", n_vec, 24);
`ifdef AGU_STAGE_DLY_EN
    chk("stage_dly_lag", t_dly1 - t_st1, 48);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
